peak_phase_avg: RTL

Downstream stage of the peak detector: collects each frame of NPEAKS peak records (frequency, magnitude, phase), computes every peak's phase relative to peak 0 with wrap to (−180°, 180°], and applies per-peak exponential averaging across frames. It presents the averaged records on a streaming output with valid/ready backpressure. Frames that arrive while the output is busy, or that are malformed, are dropped and counted.

---
 rtl/peak_phase_avg.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/peak_phase_avg.sv
`timescale 1ns/1ps
// Peak phase averager: gathers NPEAKS peak records per frame, forms phase relative to peak 0, EMA per peak.
// Latency: eop accepted at edge t -> CALC -> record 0 on source from edge t+2; one record per handshake.
// Backpressure: output held while source_valid & !source_ready; new frames arriving while busy are dropped.
// Option: define PEAK_PHASE_AVG_EN to enable exponential averaging (otherwise raw per-frame values).
module peak_phase_avg #(
  parameter int NPEAKS    = 4,
  parameter int AVG_SHIFT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sink_sop,
  input  logic                        sink_eop,
  input  logic                        sink_valid,
  input  logic [31:0]                 sink_freq,
  input  logic [31:0]                 sink_mag,
  input  logic [31:0]                 sink_phase,
  input  logic                        source_ready,
  output logic                        source_sop,
  output logic                        source_eop,
  output logic                        source_valid,
  output logic [$clog2(NPEAKS)-1:0]   source_index,
  output logic [31:0]                 source_freq,
  output logic [31:0]                 source_mag,
  output logic [31:0]                 source_dphase,
  output logic [7:0]                  dropped_frames
);

  localparam int IW = $clog2(NPEAKS);
  localparam logic [IW-1:0] LAST = IW'(NPEAKS - 1);
  localparam logic signed [32:0] PH_HALF = 33'sd46080;
  localparam logic signed [32:0] PH_SPAN = 33'sd92160;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CALC, S_EMIT} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] freq_q [NPEAKS];
  logic [31:0] freq_d [NPEAKS];
  logic [31:0] mag_q  [NPEAKS];
  logic [31:0] mag_d  [NPEAKS];
  logic [31:0] ph_q   [NPEAKS];
  logic [31:0] ph_d   [NPEAKS];
  // Per-peak results of the last CALC; with averaging enabled these are the running averages.
  logic [31:0] res_mag_q [NPEAKS];
  logic [31:0] res_mag_d [NPEAKS];
  logic [31:0] res_dph_q [NPEAKS];
  logic [31:0] res_dph_d [NPEAKS];
  logic [31:0] calc_mag  [NPEAKS];
  logic [31:0] calc_dph  [NPEAKS];
`ifdef PEAK_PHASE_AVG_EN
  logic first_q, first_d;
`endif
  logic          src_vld_q, src_vld_d, src_sop_q, src_sop_d, src_eop_q, src_eop_d;
  logic [IW-1:0] src_idx_q, src_idx_d;
  logic [31:0]   src_freq_q, src_freq_d, src_mag_q, src_mag_d, src_dph_q, src_dph_d;
  logic [7:0]    drop_q, drop_d;
  logic          drop_inc, ld_en;
  logic [IW-1:0] ld_idx;

  function automatic logic signed [32:0] sx(input logic [31:0] v);
    return $signed({v[31], v});
  endfunction

  // Fold a phase difference back into (-46080, 46080]; inputs never exceed one span out of range.
  function automatic logic signed [32:0] wrap_ph(input logic signed [32:0] d);
    logic signed [32:0] r;
    r = d;
    if (d > PH_HALF) r = d - PH_SPAN;
    else if (d <= -PH_HALF) r = d + PH_SPAN;
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: frame collection, one-cycle calculation, streaming emit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sink_valid && sink_sop) state_d = S_COLLECT;
      S_COLLECT: if (sink_valid && !sink_sop) begin
                   if (sink_eop)           state_d = (idx_q == LAST) ? S_CALC : S_IDLE;
                   else if (idx_q == LAST) state_d = S_IDLE;
                 end
      S_CALC:    state_d = S_EMIT;
      S_EMIT:    if (src_vld_q && source_ready && src_eop_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Relative phase and (optionally) averaged values for every peak of the collected frame.
  always_comb begin
    logic signed [32:0] dk, em, am, ep, ap;
    for (int k = 0; k < NPEAKS; k++) begin
      dk = wrap_ph(sx(ph_q[k]) - sx(ph_q[0]));
      em = '0; am = '0; ep = '0; ap = '0;
`ifdef PEAK_PHASE_AVG_EN
      if (first_q) begin
        calc_mag[k] = mag_q[k];
        calc_dph[k] = dk[31:0];
      end else begin
        em = sx(mag_q[k]) - sx(res_mag_q[k]);
        am = sx(res_mag_q[k]) + (em >>> AVG_SHIFT);
        ep = wrap_ph(dk - sx(res_dph_q[k]));
        ap = wrap_ph(sx(res_dph_q[k]) + (ep >>> AVG_SHIFT));
        calc_mag[k] = am[31:0];
        calc_dph[k] = ap[31:0];
      end
`else
      calc_mag[k] = mag_q[k];
      calc_dph[k] = dk[31:0];
`endif
    end
  end

  // Datapath and output-register next values per state.
  always_comb begin
    idx_d      = idx_q;
    freq_d     = freq_q;
    mag_d      = mag_q;
    ph_d       = ph_q;
    res_mag_d  = res_mag_q;
    res_dph_d  = res_dph_q;
`ifdef PEAK_PHASE_AVG_EN
    first_d    = first_q;
`endif
    src_vld_d  = src_vld_q;
    src_sop_d  = src_sop_q;
    src_eop_d  = src_eop_q;
    src_idx_d  = src_idx_q;
    src_freq_d = src_freq_q;
    src_mag_d  = src_mag_q;
    src_dph_d  = src_dph_q;
    drop_d     = drop_q;
    drop_inc   = 1'b0;
    ld_en      = 1'b0;
    ld_idx     = '0;
    case (state_q)
      S_IDLE: if (sink_valid && sink_sop) begin
        freq_d[0] = sink_freq; mag_d[0] = sink_mag; ph_d[0] = sink_phase;
        idx_d     = IW'(1);
      end
      S_COLLECT: if (sink_valid) begin
        if (sink_sop) begin
          // A new frame preempts the partial one, which is lost.
          freq_d[0] = sink_freq; mag_d[0] = sink_mag; ph_d[0] = sink_phase;
          idx_d     = IW'(1);
          drop_inc  = 1'b1;
        end else begin
          freq_d[idx_q] = sink_freq; mag_d[idx_q] = sink_mag; ph_d[idx_q] = sink_phase;
          if (sink_eop)           drop_inc = (idx_q != LAST);
          else if (idx_q == LAST) drop_inc = 1'b1;
          else                    idx_d    = idx_q + IW'(1);
        end
      end
      S_CALC: begin
        res_mag_d = calc_mag;
        res_dph_d = calc_dph;
`ifdef PEAK_PHASE_AVG_EN
        first_d   = 1'b0;
`endif
        drop_inc  = sink_valid && sink_sop;
      end
      S_EMIT: begin
        drop_inc = sink_valid && sink_sop;
        if (!src_vld_q) begin
          ld_en  = 1'b1;
          ld_idx = '0;
        end else if (source_ready) begin
          if (src_eop_q) begin
            src_vld_d = 1'b0;
            src_sop_d = 1'b0;
            src_eop_d = 1'b0;
          end else begin
            ld_en  = 1'b1;
            ld_idx = src_idx_q + IW'(1);
          end
        end
      end
      default: ;
    endcase
    if (ld_en) begin
      src_vld_d  = 1'b1;
      src_idx_d  = ld_idx;
      src_sop_d  = (ld_idx == '0);
      src_eop_d  = (ld_idx == LAST);
      src_freq_d = freq_q[ld_idx];
      src_mag_d  = res_mag_q[ld_idx];
      src_dph_d  = res_dph_q[ld_idx];
    end
    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // Data and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      for (int k = 0; k < NPEAKS; k++) begin
        freq_q[k]    <= '0;
        mag_q[k]     <= '0;
        ph_q[k]      <= '0;
        res_mag_q[k] <= '0;
        res_dph_q[k] <= '0;
      end
`ifdef PEAK_PHASE_AVG_EN
      first_q    <= 1'b1;
`endif
      src_vld_q  <= 1'b0;
      src_sop_q  <= 1'b0;
      src_eop_q  <= 1'b0;
      src_idx_q  <= '0;
      src_freq_q <= '0;
      src_mag_q  <= '0;
      src_dph_q  <= '0;
      drop_q     <= '0;
    end else begin
      idx_q      <= idx_d;
      freq_q     <= freq_d;
      mag_q      <= mag_d;
      ph_q       <= ph_d;
      res_mag_q  <= res_mag_d;
      res_dph_q  <= res_dph_d;
`ifdef PEAK_PHASE_AVG_EN
      first_q    <= first_d;
`endif
      src_vld_q  <= src_vld_d;
      src_sop_q  <= src_sop_d;
      src_eop_q  <= src_eop_d;
      src_idx_q  <= src_idx_d;
      src_freq_q <= src_freq_d;
      src_mag_q  <= src_mag_d;
      src_dph_q  <= src_dph_d;
      drop_q     <= drop_d;
    end
  end

  assign source_valid   = src_vld_q;
  assign source_sop     = src_sop_q;
  assign source_eop     = src_eop_q;
  assign source_index   = src_idx_q;
  assign source_freq    = src_freq_q;
  assign source_mag     = src_mag_q;
  assign source_dphase  = src_dph_q;
  assign dropped_frames = drop_q;

endmodule
